// File: rtl/norz_seq_pkg.sv
// ---------------------------------------------------------------------------
// norz_seq_pkg
//   Shared definitions for the opcode fetch / phase sequencer:
//     - seq_state_t   : sequencer state (FETCH, EXEC)
//     - PREFIX_ED     : opcode byte that opens the ED (XOTR) page
//     - XPT_W_DEFAULT : default width of the XPT phase counter
//     - invert8       : helper producing the complement of a byte
// ---------------------------------------------------------------------------
package norz_seq_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } seq_state_t;

  localparam logic [7:0] PREFIX_ED     = 8'hED;
  localparam int         XPT_W_DEFAULT = 5;

  function automatic logic [7:0] invert8(input logic [7:0] value);
    return ~value;
  endfunction

endpackage : norz_seq_pkg

// File: rtl/norz_xpt_counter.sv
// ---------------------------------------------------------------------------
// norz_xpt_counter
//   Execution-phase (XPT) counter. Clear has priority over increment; with
//   neither asserted the count holds.
//
//   Ports
//     clk     in   1      rising-edge clock
//     rst_n   in   1      asynchronous active-low reset (count -> 0)
//     clr     in   1      load zero on the next edge
//     inc     in   1      add one on the next edge (ignored while clr=1)
//     count   out  XPT_W  current phase
//     at_max  out  1      count is all-ones (terminal count)
// ---------------------------------------------------------------------------
module norz_xpt_counter
  import norz_seq_pkg::*;
#(
  parameter int XPT_W = XPT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [XPT_W-1:0] count,
  output logic             at_max
);

  localparam logic [XPT_W-1:0] ONE = {{(XPT_W-1){1'b0}}, 1'b1};

  logic [XPT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + ONE;
    end
  end

  assign count  = count_q;
  assign at_max = &count_q;

endmodule : norz_xpt_counter

// File: rtl/norz_xotr_phase_sequencer.sv
// ---------------------------------------------------------------------------
// norz_xotr_phase_sequencer
//   Closes the fetch/execute loop for the opcode decoders. In FETCH it
//   requests opcode bytes and latches them into Source, entering XOTR mode
//   on an ED prefix. In EXEC it runs the XPT phase counter, drives the
//   decoder page enables and samples the decoders' sequencing pulses.
//
//   Optional feature macro: NORZ_XPT_WATCHDOG_EN
//     defined   : XPT reaching all-ones in EXEC without PR_Reset_XPT or
//                 P2_Set_CM1 raises a sticky Fault and aborts to FETCH with
//                 XOTR and XPT cleared.
//     undefined : XPT wraps modulo 2^XPT_W and Fault is tied to 0.
//
//   Ports
//     Clock          in   1      rising-edge clock
//     notReset       in   1      asynchronous active-low reset
//     Fetch_Req      out  1      opcode fetch request (M1), registered
//     Fetch_Ready    in   1      fetch data valid, only honoured in FETCH
//     Fetch_Data     in   8      opcode byte
//     Wait           in   1      stall: XPT frozen, pulses ignored,
//                                decoder enables forced low
//     PR_Reset_XPT   in   1      decoder pulse: clear XPT
//     P2_Set_CM1     in   1      decoder pulse: end instruction, fetch next
//     P2_Reset_XOTR  in   1      decoder pulse: leave XOTR mode
//     XPT / notXPT   out  XPT_W  phase counter and its complement
//     Source / notSource out 8   latched opcode and its complement
//     XOTR_Enable    out  1      enable for the ED-page decoder
//     BASE_Enable    out  1      enable for the unprefixed decoder
//     Fault          out  1      sticky XPT watchdog fault
// ---------------------------------------------------------------------------
module norz_xotr_phase_sequencer
  import norz_seq_pkg::*;
#(
  parameter int         XPT_W     = XPT_W_DEFAULT,
  parameter logic [7:0] PREFIX_OP = PREFIX_ED
) (
  input  logic             Clock,
  input  logic             notReset,
  output logic             Fetch_Req,
  input  logic             Fetch_Ready,
  input  logic [7:0]       Fetch_Data,
  input  logic             Wait,
  input  logic             PR_Reset_XPT,
  input  logic             P2_Set_CM1,
  input  logic             P2_Reset_XOTR,
  output logic [XPT_W-1:0] XPT,
  output logic [XPT_W-1:0] notXPT,
  output logic [7:0]       Source,
  output logic [7:0]       notSource,
  output logic             XOTR_Enable,
  output logic             BASE_Enable,
  output logic             Fault
);

  seq_state_t       state_q;
  logic             fetch_req_q;
  logic [7:0]       source_q;
  logic             xotr_q;

  logic [XPT_W-1:0] xpt;
  logic             xpt_at_max;
  logic             xpt_clr;
  logic             xpt_inc;

  logic             in_fetch;
  logic             in_exec;
  logic             is_prefix;
  logic             prefix_entry;
  logic             opcode_load;
  logic             exec_adv;

  // An ED byte only opens the prefix page when not already in it; a second
  // ED while XOTR=1 is an ordinary opcode of the ED page.
  assign in_fetch     = (state_q == FETCH);
  assign in_exec      = (state_q == EXEC);
  assign is_prefix    = (Fetch_Data == PREFIX_OP);
  assign prefix_entry = in_fetch & Fetch_Ready & is_prefix & ~xotr_q;
  assign opcode_load  = in_fetch & Fetch_Ready & ~prefix_entry;

  // Wait freezes the whole execute side: no count, no pulse sampling.
  assign exec_adv = in_exec & ~Wait;

  // Terminal count is folded into the clear so the wrap to zero is explicit;
  // with the watchdog enabled the abort also lands on XPT=0, so the same
  // clear term serves both builds.
  assign xpt_clr = opcode_load | (exec_adv & (PR_Reset_XPT | xpt_at_max));
  assign xpt_inc = exec_adv;

  norz_xpt_counter #(
    .XPT_W (XPT_W)
  ) u_xpt_counter (
    .clk    (Clock),
    .rst_n  (notReset),
    .clr    (xpt_clr),
    .inc    (xpt_inc),
    .count  (xpt),
    .at_max (xpt_at_max)
  );

`ifdef NORZ_XPT_WATCHDOG_EN
  logic fault_q;
  logic wd_trip;

  // A runaway instruction: the phase counter is about to wrap and the
  // decoder has neither restarted the phase nor ended the instruction.
  assign wd_trip = exec_adv & xpt_at_max & ~PR_Reset_XPT & ~P2_Set_CM1;

  always_ff @(posedge Clock or negedge notReset) begin
    if (!notReset) begin
      fault_q <= 1'b0;
    end else if (wd_trip) begin
      fault_q <= 1'b1;
    end
  end

  assign Fault = fault_q;
`else
  logic wd_trip;

  assign wd_trip = 1'b0;
  assign Fault   = 1'b0;
`endif

  // Sequencer FSM: state, registered fetch request, opcode latch, XOTR mode.
  always_ff @(posedge Clock or negedge notReset) begin
    if (!notReset) begin
      state_q     <= FETCH;
      fetch_req_q <= 1'b1;
      source_q    <= 8'h00;
      xotr_q      <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (Fetch_Ready) begin
            source_q <= Fetch_Data;
            if (prefix_entry) begin
              // Stay in FETCH with the request held for the second byte.
              xotr_q <= 1'b1;
            end else begin
              state_q     <= EXEC;
              fetch_req_q <= 1'b0;
            end
          end
        end
        EXEC: begin
          if (exec_adv) begin
            if (P2_Reset_XOTR) begin
              xotr_q <= 1'b0;
            end
            if (P2_Set_CM1 || wd_trip) begin
              state_q     <= FETCH;
              fetch_req_q <= 1'b1;
            end
            if (wd_trip) begin
              xotr_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= FETCH;
          fetch_req_q <= 1'b1;
        end
      endcase
    end
  end

  // Decoder enables react to Wait in the same cycle so a stalled phase
  // never fires decoder outputs.
  assign XOTR_Enable = in_exec & xotr_q & ~Wait;
  assign BASE_Enable = in_exec & ~xotr_q & ~Wait;

  assign Fetch_Req = fetch_req_q;
  assign XPT       = xpt;
  assign notXPT    = ~xpt;
  assign Source    = source_q;
  assign notSource = invert8(source_q);

endmodule : norz_xotr_phase_sequencer

// File: tb/tb_norz_xotr_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_norz_xotr_phase_sequencer
//   Self-checking bench for norz_xotr_phase_sequencer. A behavioural model
//   (integer phase, byte opcode, mode flags) tracks the sequencer from the
//   fetch/execute rules; directed scenarios and a randomized run compare the
//   DUT outputs against it. Honours NORZ_XPT_WATCHDOG_EN like the RTL.
// ---------------------------------------------------------------------------
module tb_norz_xotr_phase_sequencer;

  localparam int XPT_W = 5;
  localparam int XPT_MOD = 1 << XPT_W;

`ifdef NORZ_XPT_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic             Clock = 1'b0;
  logic             notReset;
  logic             Fetch_Req;
  logic             Fetch_Ready;
  logic [7:0]       Fetch_Data;
  logic             Wait;
  logic             PR_Reset_XPT;
  logic             P2_Set_CM1;
  logic             P2_Reset_XOTR;
  logic [XPT_W-1:0] XPT;
  logic [XPT_W-1:0] notXPT;
  logic [7:0]       Source;
  logic [7:0]       notSource;
  logic             XOTR_Enable;
  logic             BASE_Enable;
  logic             Fault;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model
  bit       m_exec;
  int       m_xpt;
  bit [7:0] m_src;
  bit       m_xotr;
  bit       m_fault;

  always #5 Clock = ~Clock;

  norz_xotr_phase_sequencer #(
    .XPT_W     (XPT_W),
    .PREFIX_OP (8'hED)
  ) dut (
    .Clock         (Clock),
    .notReset      (notReset),
    .Fetch_Req     (Fetch_Req),
    .Fetch_Ready   (Fetch_Ready),
    .Fetch_Data    (Fetch_Data),
    .Wait          (Wait),
    .PR_Reset_XPT  (PR_Reset_XPT),
    .P2_Set_CM1    (P2_Set_CM1),
    .P2_Reset_XOTR (P2_Reset_XOTR),
    .XPT           (XPT),
    .notXPT        (notXPT),
    .Source        (Source),
    .notSource     (notSource),
    .XOTR_Enable   (XOTR_Enable),
    .BASE_Enable   (BASE_Enable),
    .Fault         (Fault)
  );

  function automatic bit exp_fetch_req();
    return !m_exec;
  endfunction

  function automatic bit exp_xotr_en();
    return m_exec && m_xotr && !Wait;
  endfunction

  function automatic bit exp_base_en();
    return m_exec && !m_xotr && !Wait;
  endfunction

  task automatic model_reset();
    m_exec  = 1'b0;
    m_xpt   = 0;
    m_src   = 8'h00;
    m_xotr  = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic idle_inputs();
    Fetch_Ready   = 1'b0;
    Fetch_Data    = 8'h00;
    Wait          = 1'b0;
    PR_Reset_XPT  = 1'b0;
    P2_Set_CM1    = 1'b0;
    P2_Reset_XOTR = 1'b0;
  endtask

  // One clock: work out the model's next state from the inputs as they stand
  // before the edge, let the edge pass, then commit. Returns at edge + 1.
  task automatic tick();
    bit       n_exec  = m_exec;
    int       n_xpt   = m_xpt;
    bit [7:0] n_src   = m_src;
    bit       n_xotr  = m_xotr;
    bit       n_fault = m_fault;
    if (!m_exec) begin
      if (Fetch_Ready) begin
        n_src = Fetch_Data;
        if (Fetch_Data == 8'hED && !m_xotr) begin
          n_xotr = 1'b1;
        end else begin
          n_exec = 1'b1;
          n_xpt  = 0;
        end
      end
    end else if (!Wait) begin
      n_xpt = PR_Reset_XPT ? 0 : (m_xpt + 1) % XPT_MOD;
      if (P2_Reset_XOTR) n_xotr = 1'b0;
      if (P2_Set_CM1) n_exec = 1'b0;
      if (WD_ON && m_xpt == XPT_MOD - 1 && !PR_Reset_XPT && !P2_Set_CM1) begin
        n_fault = 1'b1;
        n_exec  = 1'b0;
        n_xotr  = 1'b0;
        n_xpt   = 0;
      end
    end
    @(posedge Clock);
    #1;
    m_exec  = n_exec;
    m_xpt   = n_xpt;
    m_src   = n_src;
    m_xotr  = n_xotr;
    m_fault = n_fault;
  endtask

  task automatic fetch_byte(input logic [7:0] b);
    Fetch_Ready = 1'b1;
    Fetch_Data  = b;
    tick();
    Fetch_Ready = 1'b0;
    Fetch_Data  = 8'h00;
  endtask

  task automatic end_instruction();
    P2_Set_CM1    = 1'b1;
    P2_Reset_XOTR = 1'b1;
    tick();
    P2_Set_CM1    = 1'b0;
    P2_Reset_XOTR = 1'b0;
  endtask

  task automatic test_reset();
    fetch_byte(8'h00);
    repeat (7) tick();
    n_vec++;
    if (XPT !== 5'(m_xpt) || m_xpt != 7) begin
      n_err++;
      $display("FAIL reset_pre_xpt: got %0d want 7 (model %0d)", XPT, m_xpt);
    end
    #2;
    notReset = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (XPT !== 5'd0 || notXPT !== 5'h1F) begin
      n_err++;
      $display("FAIL reset_xpt: got %0d/%h want 0/1f", XPT, notXPT);
    end
    n_vec++;
    if (Fetch_Req !== 1'b1 || XOTR_Enable !== 1'b0 || BASE_Enable !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: req=%b xe=%b be=%b want 1 0 0", Fetch_Req, XOTR_Enable, BASE_Enable);
    end
    n_vec++;
    if (Source !== 8'h00 || notSource !== 8'hFF || Fault !== 1'b0) begin
      n_err++;
      $display("FAIL reset_src: src=%h nsrc=%h fault=%b want 00 ff 0", Source, notSource, Fault);
    end
    @(negedge Clock);
    notReset = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_prefix();
    fetch_byte(8'hED);
    n_vec++;
    if (Fetch_Req !== 1'b1 || XOTR_Enable !== 1'b0) begin
      n_err++;
      $display("FAIL prefix_hold: req=%b xe=%b want 1 0", Fetch_Req, XOTR_Enable);
    end
    fetch_byte(8'h44);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (XPT !== 5'(i) || Source !== 8'h44 || XOTR_Enable !== 1'b1 || BASE_Enable !== 1'b0) begin
        n_err++;
        $display("FAIL prefix_exec[%0d]: xpt=%0d src=%h xe=%b be=%b want %0d 44 1 0",
                 i, XPT, Source, XOTR_Enable, BASE_Enable, i);
      end
      tick();
    end
    end_instruction();
  endtask

  task automatic test_base();
    fetch_byte(8'h00);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (XPT !== 5'(i) || BASE_Enable !== 1'b1 || XOTR_Enable !== 1'b0 || Fetch_Req !== 1'b0) begin
        n_err++;
        $display("FAIL base_exec[%0d]: xpt=%0d be=%b xe=%b req=%b want %0d 1 0 0",
                 i, XPT, BASE_Enable, XOTR_Enable, Fetch_Req, i);
      end
      tick();
    end
    end_instruction();
  endtask

  task automatic test_simultaneous();
    fetch_byte(8'hED);
    fetch_byte(8'h10);
    repeat (4) tick();
    PR_Reset_XPT  = 1'b1;
    P2_Set_CM1    = 1'b1;
    P2_Reset_XOTR = 1'b1;
    tick();
    idle_inputs();
    n_vec++;
    if (XPT !== 5'd0 || Fetch_Req !== 1'b1 || m_xotr != 1'b0) begin
      n_err++;
      $display("FAIL simul_pulses: xpt=%0d req=%b want 0 1", XPT, Fetch_Req);
    end
    // XOTR cleared: the next opcode must run on the unprefixed decoder.
    fetch_byte(8'h21);
    n_vec++;
    if (BASE_Enable !== 1'b1 || XOTR_Enable !== 1'b0) begin
      n_err++;
      $display("FAIL simul_xotr: be=%b xe=%b want 1 0", BASE_Enable, XOTR_Enable);
    end
    end_instruction();
  endtask

  task automatic test_wait();
    fetch_byte(8'h33);
    repeat (2) tick();
    Wait       = 1'b1;
    P2_Set_CM1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (XPT !== 5'd2 || BASE_Enable !== 1'b0 || XOTR_Enable !== 1'b0 || Fetch_Req !== 1'b0) begin
        n_err++;
        $display("FAIL wait_hold[%0d]: xpt=%0d be=%b xe=%b req=%b want 2 0 0 0",
                 i, XPT, BASE_Enable, XOTR_Enable, Fetch_Req);
      end
      tick();
    end
    Wait       = 1'b0;
    P2_Set_CM1 = 1'b0;
    tick();
    n_vec++;
    if (XPT !== 5'd3 || Fetch_Req !== 1'b0) begin
      n_err++;
      $display("FAIL wait_release: xpt=%0d req=%b want 3 0", XPT, Fetch_Req);
    end
    end_instruction();
  endtask

  task automatic test_watchdog();
    fetch_byte(8'h00);
    repeat (XPT_MOD - 1) tick();
    n_vec++;
    if (XPT !== 5'(XPT_MOD - 1)) begin
      n_err++;
      $display("FAIL wd_pre: xpt=%0d want %0d", XPT, XPT_MOD - 1);
    end
    tick();
    n_vec++;
    if (XPT !== 5'd0 || Fault !== (WD_ON ? 1'b1 : 1'b0) || Fetch_Req !== (WD_ON ? 1'b1 : 1'b0)) begin
      n_err++;
      $display("FAIL wd_edge: xpt=%0d fault=%b req=%b want 0 %b %b",
               XPT, Fault, Fetch_Req, WD_ON, WD_ON);
    end
    if (m_exec) end_instruction();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      Fetch_Ready   = ($urandom_range(0, 3) != 0);
      Fetch_Data    = ($urandom_range(0, 2) == 0) ? 8'hED : 8'($urandom);
      Wait          = ($urandom_range(0, 4) == 0);
      PR_Reset_XPT  = ($urandom_range(0, 15) == 0);
      P2_Set_CM1    = ($urandom_range(0, 9) == 0);
      P2_Reset_XOTR = ($urandom_range(0, 7) == 0);
      #1;
      n_vec++;
      if (XOTR_Enable !== exp_xotr_en() || BASE_Enable !== exp_base_en()) begin
        n_err++;
        $display("FAIL rnd_en[%0d]: xe=%b be=%b want %b %b",
                 i, XOTR_Enable, BASE_Enable, exp_xotr_en(), exp_base_en());
      end
      tick();
      n_vec++;
      if (XPT !== 5'(m_xpt) || notXPT !== ~5'(m_xpt) || Fetch_Req !== exp_fetch_req()) begin
        n_err++;
        $display("FAIL rnd_xpt[%0d]: xpt=%0d nxpt=%h req=%b want %0d %h %b",
                 i, XPT, notXPT, Fetch_Req, m_xpt, ~5'(m_xpt), exp_fetch_req());
      end
      n_vec++;
      if (Source !== m_src || notSource !== ~m_src || Fault !== m_fault) begin
        n_err++;
        $display("FAIL rnd_src[%0d]: src=%h nsrc=%h fault=%b want %h %h %b",
                 i, Source, notSource, Fault, m_src, ~m_src, m_fault);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    notReset = 1'b0;
    model_reset();
    #12;
    notReset = 1'b1;
    @(posedge Clock);
    #1;
    test_reset();
    test_prefix();
    test_base();
    test_simultaneous();
    test_wait();
    test_watchdog();
    // Start the randomized run from a clean state (Fault is sticky).
    @(negedge Clock);
    notReset = 1'b0;
    model_reset();
    @(negedge Clock);
    notReset = 1'b1;
    @(posedge Clock);
    #1;
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_norz_xotr_phase_sequencer
